// File: rtl/bitmode_addr.sv
`default_nettype none
// ============================================================================
// Module      : bitmode_addr
// Description : CPU-loadable X/Y pixel address with one auto-step per bit-mode
//               access. Macro BITMODE_READ_INC_EN lets bit-mode reads step too.
// Revision    : 1.0 - initial release
// ============================================================================
module bitmode_addr (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce2Hd3,
    input  logic        BRWn,
    input  logic        xsel,
    input  logic        ysel,
    input  logic        bmsel,
    input  logic        csel,
    input  logic [1:0]  csel_a,
    input  logic [7:0]  BD,
    output logic [14:0] DRBA,
    output logic        PIXA,
    output logic        BITMDn
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Control latch bit positions: {YDIR, XDIR, YINC, XINC}
    localparam int C_XINC = 0;
    localparam int C_YINC = 1;
    localparam int C_XDIR = 2;
    localparam int C_YDIR = 3;

    state_t     state_q, state_d;
    logic [7:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic [3:0] ctl_q, ctl_d;
    logic       w_qual;
    logic       w_step;
    logic       w_cpu_wr;

`ifdef BITMODE_READ_INC_EN
    assign w_qual = 1'b1;
`else
    assign w_qual = ~BRWn;
`endif

    assign w_cpu_wr = ce2Hd3 & ~BRWn;

    // HOLD absorbs any further ce2Hd3 strobes so a long bmsel steps only once.
    always_comb begin
        state_d = state_q;
        w_step  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bmsel)
                    state_d = ACCESS;
            end
            ACCESS: begin
                if (!bmsel) begin
                    state_d = IDLE;
                end else if (ce2Hd3) begin
                    state_d = HOLD;
                    w_step  = w_qual;
                end
            end
            HOLD: begin
                if (!bmsel)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A direct CPU load takes priority over an auto-step in the same clock.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        ctl_d = ctl_q;
        if (w_cpu_wr && xsel)
            x_d = BD;
        else if (w_step && ctl_q[C_XINC])
            x_d = ctl_q[C_XDIR] ? x_q - 8'd1 : x_q + 8'd1;
        if (w_cpu_wr && ysel)
            y_d = BD;
        else if (w_step && ctl_q[C_YINC])
            y_d = ctl_q[C_YDIR] ? y_q - 8'd1 : y_q + 8'd1;
        if (w_cpu_wr && csel)
            ctl_d[csel_a] = BD[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            ctl_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ctl_q   <= ctl_d;
        end
    end

    assign DRBA   = {y_q, x_q[7:1]};
    assign PIXA   = x_q[0];
    assign BITMDn = ~bmsel;

endmodule
`default_nettype wire

// File: tb/tb_bitmode_addr.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitmode_addr
// Description : Scoreboard bench for bitmode_addr with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitmode_addr;

    logic        clk;
    logic        reset;
    logic        ce2Hd3;
    logic        BRWn;
    logic        xsel;
    logic        ysel;
    logic        bmsel;
    logic        csel;
    logic [1:0]  csel_a;
    logic [7:0]  BD;
    logic [14:0] DRBA;
    logic        PIXA;
    logic        BITMDn;

    bitmode_addr dut (
        .clk    (clk),
        .reset  (reset),
        .ce2Hd3 (ce2Hd3),
        .BRWn   (BRWn),
        .xsel   (xsel),
        .ysel   (ysel),
        .bmsel  (bmsel),
        .csel   (csel),
        .csel_a (csel_a),
        .BD     (BD),
        .DRBA   (DRBA),
        .PIXA   (PIXA),
        .BITMDn (BITMDn)
    );

    localparam int S_DRBA  = 0;
    localparam int S_PIXA  = 1;
    localparam int S_BITMD = 2;
    localparam int S_X     = 3;
    localparam int S_Y     = 4;
    localparam int S_STATE = 5;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    event     chk_ev;
    int       n_chk  = 0;
    int       n_pass = 0;
    logic [7:0] xe;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops every queued expectation when a sample point is presented.
    always begin
        sb_item_t    t;
        logic [15:0] obs;
        @(chk_ev);
        while (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            case (t.sel)
                S_DRBA:  obs = {1'b0, DRBA};
                S_PIXA:  obs = {15'd0, PIXA};
                S_BITMD: obs = {15'd0, BITMDn};
                S_X:     obs = {8'd0, DRBA[6:0], PIXA};
                S_Y:     obs = {8'd0, DRBA[14:7]};
                default: obs = {14'd0, dut.state_q};
            endcase
            n_chk = n_chk + 1;
            if (obs === t.exp)
                n_pass = n_pass + 1;
            else
                $display("FAIL %s: got %h, expected %h", t.name, obs, t.exp);
        end
    end

    task automatic chk(input string nm, input int sel, input logic [15:0] e);
        sb_item_t t;
        t.name = nm;
        t.sel  = sel;
        t.exp  = e;
        sb_q.push_back(t);
    endtask

    task automatic flush();
        #1;
        ->chk_ev;
        #1;
    endtask

    task automatic cpu_wr(input int kind, input logic [1:0] idx, input logic [7:0] d);
        BRWn   = 1'b0;
        BD     = d;
        csel_a = idx;
        xsel   = (kind == 0);
        ysel   = (kind == 1);
        csel   = (kind == 2);
        ce2Hd3 = 1'b1;
        @(negedge clk);
        xsel   = 1'b0;
        ysel   = 1'b0;
        csel   = 1'b0;
        ce2Hd3 = 1'b0;
        BRWn   = 1'b1;
    endtask

    // One bit-mode access; address is checked during the completing ce2Hd3 clock.
    task automatic bm(input logic rw, input int hold, input logic [14:0] e_drba,
                      input logic e_pixa);
        bmsel = 1'b1;
        BRWn  = rw;
        @(negedge clk);
        ce2Hd3 = 1'b1;
        chk("bm_drba_at_ce", S_DRBA, {1'b0, e_drba});
        chk("bm_pixa_at_ce", S_PIXA, {15'd0, e_pixa});
        chk("bm_bitmdn_low", S_BITMD, 16'd0);
        chk("bm_state_access", S_STATE, 16'd1);
        flush();
        @(negedge clk);
        ce2Hd3 = 1'b0;
        for (int i = 0; i < hold; i++) begin
            ce2Hd3 = ((i % 8) == 7);
            @(negedge clk);
        end
        ce2Hd3 = 1'b0;
        chk("bm_state_hold", S_STATE, 16'd2);
        flush();
        bmsel = 1'b0;
        BRWn  = 1'b1;
        @(negedge clk);
        chk("bm_state_idle", S_STATE, 16'd0);
        chk("bm_bitmdn_high", S_BITMD, 16'd1);
        flush();
    endtask

    initial begin
        reset  = 1'b1;
        ce2Hd3 = 1'b0;
        BRWn   = 1'b1;
        xsel   = 1'b0;
        ysel   = 1'b0;
        bmsel  = 1'b0;
        csel   = 1'b0;
        csel_a = 2'd0;
        BD     = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_x", S_X, 16'h00);
        chk("rst_y", S_Y, 16'h00);
        chk("rst_drba", S_DRBA, 16'h0000);
        chk("rst_pixa", S_PIXA, 16'd0);
        chk("rst_bitmdn", S_BITMD, 16'd1);
        chk("rst_state", S_STATE, 16'd0);
        flush();
        reset = 1'b0;
        @(negedge clk);

        // Address mapping
        cpu_wr(0, 2'd0, 8'h35);
        cpu_wr(1, 2'd0, 8'h12);
        bm(1'b1, 0, 15'h091A, 1'b1);
        chk("map_x_kept", S_X, 16'h35);
        flush();

        // Increment with wrap, bmsel held 24 clks with extra strobes
        cpu_wr(2, 2'd0, 8'h01);
        cpu_wr(0, 2'd0, 8'hFF);
        bm(1'b0, 24, 15'h097F, 1'b1);
        chk("inc_x_wrap", S_X, 16'h00);
        chk("inc_y_kept", S_Y, 16'h12);
        flush();

        // Y decrement twice from 0x00
        cpu_wr(2, 2'd0, 8'h00);
        cpu_wr(2, 2'd1, 8'h01);
        cpu_wr(2, 2'd3, 8'h01);
        cpu_wr(1, 2'd0, 8'h00);
        bm(1'b0, 2, 15'h0000, 1'b0);
        chk("dec_y_1", S_Y, 16'hFF);
        flush();
        bm(1'b0, 2, 15'h7F80, 1'b0);
        chk("dec_y_2", S_Y, 16'hFE);
        chk("dec_x_kept", S_X, 16'h00);
        flush();

        // Bit-mode read step
        cpu_wr(2, 2'd1, 8'h00);
        cpu_wr(2, 2'd0, 8'h01);
        cpu_wr(0, 2'd0, 8'h10);
        bm(1'b1, 2, 15'h7F08, 1'b0);
`ifdef BITMODE_READ_INC_EN
        xe = 8'h11;
`else
        xe = 8'h10;
`endif
        chk("read_step_x", S_X, {8'd0, xe});
        chk("read_y_kept", S_Y, 16'hFE);
        flush();

        // X decrement
        cpu_wr(2, 2'd2, 8'h01);
        bm(1'b0, 1, {8'hFE, xe[7:1]}, xe[0]);
        xe = xe - 8'd1;
        chk("dec_x", S_X, {8'd0, xe});
        flush();

        // Abort: bmsel high 3 clks, no ce2Hd3
        bmsel = 1'b1;
        BRWn  = 1'b0;
        repeat (3) @(negedge clk);
        bmsel = 1'b0;
        BRWn  = 1'b1;
        @(negedge clk);
        chk("abort_x_kept", S_X, {8'd0, xe});
        chk("abort_state", S_STATE, 16'd0);
        flush();

        // Reset mid-access, then a still-high bmsel starts a new access
        bmsel = 1'b1;
        BRWn  = 1'b0;
        @(negedge clk);
        chk("mid_state_access", S_STATE, 16'd1);
        flush();
        reset = 1'b1;
        chk("mid_rst_x", S_X, 16'h00);
        chk("mid_rst_y", S_Y, 16'h00);
        chk("mid_rst_state", S_STATE, 16'd0);
        flush();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_access", S_STATE, 16'd1);
        flush();
        ce2Hd3 = 1'b1;
        @(negedge clk);
        ce2Hd3 = 1'b0;
        chk("post_rst_hold", S_STATE, 16'd2);
        chk("post_rst_x_nostep", S_X, 16'h00);
        flush();
        bmsel = 1'b0;
        BRWn  = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", S_STATE, 16'd0);
        flush();

        #5;
        if (sb_q.size() != 0) begin
            n_chk = n_chk + 1;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
